tea_block_packer: RTL

- Upstream neighbour of tea_accelerator.
- Accepts a 32-bit AXI-Stream of plaintext words with TLAST, packs consecutive word pairs into 64-bit TEA blocks, and presents them on a 64-bit AXI-Stream master that connects directly to the accelerator's i_axis_*_s slave port.
- Pads an odd trailing word to a full block and tracks packet boundaries and block counts.

---
 rtl/tea_block_packer.sv | 117 +++++++++++
 1 files changed

// File: rtl/tea_block_packer.sv
// Packs a 32-bit AXI-Stream of plaintext words into 64-bit TEA blocks {v0, v1}, padding odd packets.
// Optional macro TEA_PACK_BYTESWAP_EN byte-reverses each input word before packing.
module tea_block_packer #(
    parameter logic [31:0] PAD_WORD = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_axis_valid_s,
    output logic              o_axis_ready_s,
    input  logic [31:0]       i_axis_data_s,
    input  logic              i_axis_last_s,
    output logic              o_axis_valid_m,
    input  logic              i_axis_ready_m,
    output logic [63:0]       o_axis_data_m,
    output logic              o_axis_last_m,
    output logic [CNT_W-1:0]  o_blk_count,
    output logic              o_padded
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BLK_W  = 64;

    typedef enum logic {
        S_HI = 1'b0,
        S_LO = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [WORD_W-1:0]   hi;
    logic [WORD_W-1:0]   hi_nxt;
    logic [WORD_W-1:0]   word;
    logic                valid_nxt;
    logic                last_nxt;
    logic                padded_nxt;
    logic [BLK_W-1:0]    data_nxt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic                slv_xfer;
    logic                mst_xfer;

`ifdef TEA_PACK_BYTESWAP_EN
    // Little-endian host words become big-endian TEA words.
    assign word = {i_axis_data_s[7:0], i_axis_data_s[15:8],
                   i_axis_data_s[23:16], i_axis_data_s[31:24]};
`else
    assign word = i_axis_data_s;
`endif

    // Accept a word whenever the output slot is free or being drained this cycle.
    assign o_axis_ready_s = ~o_axis_valid_m | i_axis_ready_m;
    assign slv_xfer       = i_axis_valid_s & o_axis_ready_s;
    assign mst_xfer       = o_axis_valid_m & i_axis_ready_m;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= S_HI;
            hi             <= '0;
            o_axis_valid_m <= 1'b0;
            o_axis_data_m  <= '0;
            o_axis_last_m  <= 1'b0;
            o_blk_count    <= '0;
            o_padded       <= 1'b0;
        end else begin
            state          <= state_nxt;
            hi             <= hi_nxt;
            o_axis_valid_m <= valid_nxt;
            o_axis_data_m  <= data_nxt;
            o_axis_last_m  <= last_nxt;
            o_blk_count    <= cnt_nxt;
            o_padded       <= padded_nxt;
        end
    end

    // Next-state: drain on master transfer first, then a completing word may reload the slot.
    always_comb begin
        state_nxt  = state;
        hi_nxt     = hi;
        valid_nxt  = o_axis_valid_m;
        data_nxt   = o_axis_data_m;
        last_nxt   = o_axis_last_m;
        cnt_nxt    = o_blk_count;
        padded_nxt = o_padded;

        if (mst_xfer) begin
            valid_nxt = 1'b0;
            cnt_nxt   = o_axis_last_m ? '0 : o_blk_count + CNT_W'(1);
        end

        if (slv_xfer) begin
            unique case (state)
                S_HI: begin
                    if (i_axis_last_s) begin
                        valid_nxt  = 1'b1;
                        data_nxt   = {word, PAD_WORD};
                        last_nxt   = 1'b1;
                        padded_nxt = 1'b1;
                    end else begin
                        hi_nxt    = word;
                        state_nxt = S_LO;
                    end
                end
                S_LO: begin
                    valid_nxt = 1'b1;
                    data_nxt  = {hi, word};
                    last_nxt  = i_axis_last_s;
                    if (i_axis_last_s) begin
                        padded_nxt = 1'b0;
                    end
                    state_nxt = S_HI;
                end
                default: state_nxt = S_HI;
            endcase
        end
    end

endmodule
